parity_frame_checker: RTL

- Serial-frame parity checker that consumes a bit stream one bit per valid cycle: DATA_BITS data bits (LSB first), then one parity bit.
- Accumulates the running XOR of the data bits with a registered accumulator, the sequential counterpart of our combinational xor/xnor parity gates.
- Checks the received parity bit, presents the assembled word with an error flag, and keeps a saturating error count.
- Sits directly downstream of the serial parity generator, at the receive end of the link.

---
 rtl/parity_frame_checker.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/parity_frame_checker.sv
// -----------------------------------------------------------------------------
// parity_frame_checker
//
// Receive-side checker for serial parity frames. Each frame is DATA_BITS data
// bits (LSB first, the first one flagged by i_start) followed by one parity
// bit. The data bits are assembled into a word while their running XOR is
// accumulated; the parity bit is then checked and the word is presented with
// an error flag and a saturating error count.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   i_valid    i_bit / i_start are meaningful this cycle
//   i_bit      serial data or parity bit
//   i_start    first data bit of a frame (qualified by i_valid)
//   o_data     data of the last completed frame (o_data[k] = k-th bit received)
//   o_valid    one-cycle pulse when a frame completes
//   o_err      parity error of the frame in o_data, held until next completion
//   o_err_cnt  saturating count of frames with parity errors
//   o_busy     a frame is in progress
// -----------------------------------------------------------------------------
module parity_frame_checker #(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_bit,
  input  logic                 i_start,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output logic                 o_busy
);

  localparam int               CNT_W    = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);
  localparam logic             ODD_BIT  = (ODD_PARITY != 0);

  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

  // A one-bit frame has no further data bits, so a start goes straight to PAR.
  localparam state_t AFTER_START = (DATA_BITS == 1) ? PAR : DATA;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt;
  logic                 acc;
  logic [DATA_BITS-1:0] shreg;

  logic                 start;
  logic                 data_take;
  logic                 done;
  logic                 err_now;
  logic [CNT_W-1:0]     wr_idx;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first means every path assigns state_next,
  // so no latch is inferred.
  always_comb begin
    state_next = state;
    if (start) begin
      // A start in any state begins a new frame; an unfinished one is dropped.
      state_next = AFTER_START;
    end else if (i_valid) begin
      unique case (state)
        IDLE:    state_next = IDLE;
        DATA:    if (cnt == LAST_IDX) state_next = PAR;
        PAR:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output / decode logic
  // ---------------------------------------------------------------------------
  always_comb begin
    start     = i_valid & i_start;
    data_take = i_valid & ~i_start & (state == DATA);
    done      = i_valid & ~i_start & (state == PAR);
    err_now   = acc ^ i_bit ^ ODD_BIT;
    wr_idx    = start ? '0 : cnt;
    o_busy    = (state != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Datapath: bit counter, parity accumulator, word assembly, result registers
  // ---------------------------------------------------------------------------
  // NOTE: the assembly register is reset along with everything else even
  // though only o_data is visible, so no X can ever reach the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= 1'b0;
      shreg     <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      o_valid <= done;

      if (start) begin
        cnt <= CNT_W'(1);
        acc <= i_bit;
      end else if (data_take) begin
        cnt <= cnt + 1'b1;
        acc <= acc ^ i_bit;
      end

      // Place the bit at its received position rather than shifting, so the
      // word is correct for any DATA_BITS including 1.
      if (start || data_take) begin
        for (int k = 0; k < DATA_BITS; k++) begin
          if (wr_idx == CNT_W'(k)) shreg[k] <= i_bit;
        end
      end

      if (done) begin
        o_data <= shreg;
        o_err  <= err_now;
        if (err_now && !(&o_err_cnt)) o_err_cnt <= o_err_cnt + 1'b1;
      end
    end
  end

endmodule
